// File: rtl/math_seq_if.sv
// math_seq_if: request/response and shared add/sub unit signals of math_seq_ctrl
interface math_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        illegal;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_sub;
  logic [7:0]  alu_sum;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_neg;
  logic        alu_zero;
  modport master (
    output req_valid, op, opa, opb, resp_ready, alu_sum, alu_cout, alu_ovf, alu_neg, alu_zero,
    input  req_ready, resp_valid, result, flags, illegal, alu_a, alu_b, alu_sub
  );
  modport slave (
    input  req_valid, op, opa, opb, resp_ready, alu_sum, alu_cout, alu_ovf, alu_neg, alu_zero,
    output req_ready, resp_valid, result, flags, illegal, alu_a, alu_b, alu_sub
  );
endinterface

// File: rtl/math_seq_ctrl.sv
// math_seq_ctrl: sequences ADD/SUB/CMP/MUL over a shared 8-bit add/sub unit; MUL present only with MATH_SEQ_MUL_EN
module math_seq_ctrl (
  input  logic      clk,
  input  logic      rst,
  math_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]  state_q, state_d, op_q, op_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        illegal_q, illegal_d;
`ifdef MATH_SEQ_MUL_EN
  localparam logic [1:0] MUL = 2'd2;
  logic [7:0]  hi_q, hi_d, lo_q, lo_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] prod;
  assign prod = {bus.alu_cout, bus.alu_sum, lo_q[7:1]};
`endif
  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == DONE;
  assign bus.result     = result_q;
  assign bus.flags      = flags_q;
  assign bus.illegal    = illegal_q;
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    bus.alu_a   = 8'h00;
    bus.alu_b   = 8'h00;
    bus.alu_sub = 1'b0;
`ifdef MATH_SEQ_MUL_EN
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.req_valid) begin
        op_d      = bus.op;
        a_d       = bus.opa;
        b_d       = bus.opb;
        illegal_d = 1'b0;
`ifdef MATH_SEQ_MUL_EN
        state_d   = bus.op == 2'b11 ? MUL : EXEC;
        hi_d      = 8'h00;
        lo_d      = bus.opa;
        cnt_d     = 3'd0;
`else
        state_d   = EXEC;
`endif
      end
      EXEC: begin
        bus.alu_a   = a_q;
        bus.alu_b   = b_q;
        bus.alu_sub = op_q[0] ^ op_q[1];
        state_d     = DONE;
        result_d    = op_q[1] ? 16'h0000 : {8'h00, bus.alu_sum};
        flags_d     = {bus.alu_neg, bus.alu_zero, bus.alu_ovf, bus.alu_cout};
`ifndef MATH_SEQ_MUL_EN
        if (op_q == 2'b11) begin
          result_d  = 16'h0000;
          flags_d   = 4'h0;
          illegal_d = 1'b1;
        end
`endif
      end
`ifdef MATH_SEQ_MUL_EN
      MUL: begin
        bus.alu_a = hi_q;
        bus.alu_b = lo_q[0] ? b_q : 8'h00;
        hi_d      = prod[15:8];
        lo_d      = prod[7:0];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d  = DONE;
          result_d = prod;
          flags_d  = {prod[15], prod == 16'h0000, 1'b0, |prod[15:8]};
        end
      end
`endif
      default: state_d = bus.resp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      result_q  <= 16'h0000;
      flags_q   <= 4'h0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end
`ifdef MATH_SEQ_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= 8'h00;
      lo_q  <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_math_seq_ctrl.sv
// tb_math_seq_ctrl: scoreboard bench for math_seq_ctrl with a behavioural shared add/sub unit
module tb_math_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  math_seq_if bus ();
  math_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    logic        il;
    int          lat;
  } exp_t;
  exp_t sb_q[$];
  logic [8:0] s9;
  assign s9 = bus.alu_sub ? {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1 : {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_sum  = s9[7:0];
  assign bus.alu_cout = s9[8];
  assign bus.alu_neg  = s9[7];
  assign bus.alu_zero = s9[7:0] == 8'h00;
  assign bus.alu_ovf  = bus.alu_sub ? (bus.alu_a[7] != bus.alu_b[7]) && (s9[7] != bus.alu_a[7])
                                    : (bus.alu_a[7] == bus.alu_b[7]) && (s9[7] != bus.alu_a[7]);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb, s;
    logic [15:0] p;
    sa = $signed(a);
    sb = $signed(b);
    e.il = 1'b0;
    e.lat = 1;
    case (o)
      2'b00: begin
        p = 16'(a) + 16'(b);
        s = sa + sb;
        e.r = {8'h00, p[7:0]};
        e.f = {p[7], p[7:0] == 8'h00, (s > 127) || (s < -128), p[8]};
      end
      2'b01, 2'b10: begin
        p = 16'(a) - 16'(b);
        s = sa - sb;
        e.r = o[1] ? 16'h0000 : {8'h00, p[7:0]};
        e.f = {p[7], p[7:0] == 8'h00, (s > 127) || (s < -128), a >= b};
      end
      default: begin
`ifdef MATH_SEQ_MUL_EN
        p = 16'(a) * 16'(b);
        e.r = p;
        e.f = {p[15], p == 16'h0000, 1'b0, p[15:8] != 8'h00};
        e.lat = 8;
`else
        e.r = 16'h0000;
        e.f = 4'h0;
        e.il = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction
  task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    int n;
    sb_q.push_back(model(o, a, b));
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.opa = a;
    bus.opb = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    if (!bus.resp_valid) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    chk("latency", n, e.lat);
    chk("result", bus.result, e.r);
    chk("flags", bus.flags, e.f);
    chk("illegal", bus.illegal, e.il);
    chk("no_ready_in_done", bus.req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_ready", bus.req_ready, 0);
      chk("hold_result", bus.result, e.r);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("idle_ready", bus.req_ready, 1);
    chk("idle_no_resp", bus.resp_valid, 0);
    chk("idle_keep_result", bus.result, e.r);
  endtask
  task automatic mid_reset(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input int dly);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.opa = a;
    bus.opb = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (dly) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_resp", bus.resp_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    repeat (10) begin
      @(negedge clk);
      chk("rst_no_resp", bus.resp_valid, 0);
    end
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op = 2'b00;
    bus.opa = 8'h00;
    bus.opb = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_resp", bus.resp_valid, 0);
    chk("reset_result", bus.result, 0);
    chk("reset_flags", bus.flags, 0);
    chk("reset_illegal", bus.illegal, 0);
    chk("reset_alu", {bus.alu_a, bus.alu_b, 7'd0, bus.alu_sub}, 0);
    do_op(2'b00, 8'h7F, 8'h01, 0);
    do_op(2'b01, 8'h05, 8'h05, 0);
    do_op(2'b10, 8'h03, 8'h04, 0);
    do_op(2'b11, 8'hFF, 8'hFF, 0);
    do_op(2'b11, 8'h00, 8'h37, 0);
    do_op(2'b00, 8'h10, 8'h20, 5);
    do_op(2'b11, 8'h03, 8'h04, 0);
    do_op(2'b00, 8'h22, 8'h11, 0);
`ifdef MATH_SEQ_MUL_EN
    mid_reset(2'b11, 8'hAB, 8'hCD, 4);
`else
    mid_reset(2'b00, 8'h40, 8'h02, 2);
`endif
    do_op(2'b00, 8'h01, 8'h01, 0);
    for (int i = 0; i < 24; i++)
      do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/math_seq_ctrl.md
MATH_SEQ_CTRL -- requirements
Module: math_seq_ctrl

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  controller can accept a request.
REQ-006 op  in  2  00 ADD, 01 SUB, 10 CMP, 11 MUL.
REQ-007 opa, opb  in  8 each  operands, unsigned for MUL.
REQ-008 resp_valid  out  1  result/flags available.
REQ-009 resp_ready  in  1  consumer accepts response.
REQ-010 result  out  16  operation result.
REQ-011 flags  out  4  {N,Z,V,C}.
REQ-012 illegal  out  1  current response is for an unsupported op.
REQ-013 alu_a, alu_b  out  8 each  operands driven to the shared 8-bit add/sub unit.
REQ-014 alu_sub  out  1  subtract control to the shared unit.
REQ-015 alu_sum in 8; alu_cout, alu_ovf, alu_neg, alu_zero in 1 each  shared-unit outputs, combinational from alu_a/alu_b/alu_sub.

Function
REQ-016 FSM states IDLE, EXEC, MUL, DONE; req_ready=1 only in IDLE, so req_ready and resp_valid are never both 1.
REQ-017 IDLE: on req_valid=1, latch op/opa/opb; go to EXEC for ADD/SUB/CMP, MUL for MUL.
REQ-018 EXEC: drive alu_a=opa, alu_b=opb, alu_sub=1 for SUB/CMP, 0 for ADD; at the next edge capture the outputs and go to DONE (resp_valid 1 cycle after acceptance).
REQ-019 ADD/SUB: result={8'h00, alu_sum}; flags={alu_neg, alu_zero, alu_ovf, alu_cout}; for SUB, C=1 means no borrow.
REQ-020 CMP: flags as SUB; result=16'h0000.
REQ-021 MUL: unsigned shift-add over 8 cycles with 3-bit step counter 0..7; alu_a=acc_hi, alu_b=opb if mplier[0] else 8'h00, alu_sub=0.
REQ-022 MUL step: {acc_hi, acc_lo} <= {alu_cout, alu_sum, acc_lo[7:1]}; acc_lo is seeded with opa and serves as the multiplier; acc_hi starts at 0.
REQ-023 After step 7, go to DONE (resp_valid 8 cycles after acceptance); result={acc_hi, acc_lo}; flags N=result[15], Z=(result==0), V=0, C=(result[15:8]!=0).
REQ-024 DONE: resp_valid=1; result, flags and illegal held stable until resp_valid&resp_ready, then IDLE on the next edge.
REQ-025 Outside EXEC/MUL, alu_a, alu_b and alu_sub are driven 0.
REQ-026 result and flags keep their last value in IDLE until the next response is captured.

Reset
REQ-027 rst=1 at any edge, including mid-MUL or mid-DONE, forces IDLE and discards any in-flight op with no response.
REQ-028 Reset values: req_ready=1 (after the reset edge), resp_valid=0, result=0, flags=0, illegal=0, alu_*=0, counter=0.

Configuration
REQ-029 Macro MATH_SEQ_MUL_EN: when defined, MUL behaves per REQ-021..023 and illegal is always 0.
REQ-030 When MATH_SEQ_MUL_EN is undefined, MUL logic is absent; op=11 goes IDLE->DONE in 1 cycle with illegal=1, result=0, flags=0; illegal clears on the next accepted op.

Verification
REQ-031 ADD 0x7F+0x01 -> resp_valid 1 cycle after accept, result=0x0080, flags N=1 Z=0 V=1 C=0.
REQ-032 SUB 0x05-0x05 -> result=0x0000, flags N=0 Z=1 V=0 C=1; CMP 0x03 vs 0x04 -> result=0, N=1 Z=0 V=0 C=0.
REQ-033 MUL 0xFF*0xFF (macro on) -> resp_valid 8 cycles after accept, result=0xFE01, N=1 Z=0 V=0 C=1; MUL 0x00*0x37 -> 0x0000, Z=1.
REQ-034 Hold resp_ready=0 for 5 cycles after ADD 0x10+0x20 with req_valid=1 -> result 0x0030 stable, req_ready=0, no second accept until the handshake.
REQ-035 Assert rst during MUL step 4 -> next cycle IDLE, resp_valid=0, result=0; the following ADD 0x01+0x01 returns 0x0002.
REQ-036 Macro off: MUL 0x03*0x04 -> resp 1 cycle after accept, illegal=1, result=0; the next ADD returns illegal=0.
